// File: rtl/memory_pkg.sv
// Shared memory-access types: access-size encoding and the size-to-byte-mask helper.
package memory_pkg;

    localparam int MEM_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'd0,
        MEM_HALF    = 2'd1,
        MEM_WORD    = 2'd2,
        MEM_ILLEGAL = 2'd3
    } e_mem_size;

    function automatic logic [3:0] size_to_mask(input e_mem_size size);
        case (size)
            MEM_BYTE: return 4'b0001;
            MEM_HALF: return 4'b0011;
            MEM_WORD: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering: store byte enables and lane replication, load lane select and sign/zero extension.
// Purely combinational, zero latency, no flow control.
module dmem_lane_ctrl
    import memory_pkg::*;
(
    input  logic [1:0]                i_st_size,
    input  logic [1:0]                i_st_off,
    input  logic [MEM_WORD_WIDTH-1:0] i_st_dat,
    output logic [3:0]                o_st_be,
    output logic [MEM_WORD_WIDTH-1:0] o_st_dat,
    input  logic [1:0]                i_ld_size,
    input  logic [1:0]                i_ld_off,
    input  logic                      i_ld_unsigned,
    input  logic [MEM_WORD_WIDTH-1:0] i_ld_word,
    output logic [MEM_WORD_WIDTH-1:0] o_ld_dat
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    assign o_st_be = size_to_mask(e_mem_size'(i_st_size)) << i_st_off;

    // Replicating into every lane lets the byte enables alone pick the destination.
    always_comb begin
        o_st_dat = '0;
        case (e_mem_size'(i_st_size))
            MEM_BYTE: o_st_dat = {4{i_st_dat[7:0]}};
            MEM_HALF: o_st_dat = {2{i_st_dat[15:0]}};
            MEM_WORD: o_st_dat = i_st_dat;
            default:  o_st_dat = '0;
        endcase
    end

    assign w_ld_byte = i_ld_word[{i_ld_off, 3'b000} +: 8];
    assign w_ld_half = i_ld_word[{i_ld_off[1], 4'b0000} +: 16];

    always_comb begin
        o_ld_dat = '0;
        case (e_mem_size'(i_ld_size))
            MEM_BYTE: o_ld_dat = i_ld_unsigned ? {24'h0, w_ld_byte}
                                               : {{24{w_ld_byte[7]}}, w_ld_byte};
            MEM_HALF: o_ld_dat = i_ld_unsigned ? {16'h0, w_ld_half}
                                               : {{16{w_ld_half[15]}}, w_ld_half};
            MEM_WORD: o_ld_dat = i_ld_word;
            default:  o_ld_dat = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: byte/half/word access to a word array, ack RD_LATENCY cycles after each request, no backpressure.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses are rejected instead of force-aligned.
module data_memory_responder
    import memory_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    input  logic                      write_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [1:0]                n_bytes_i,
    input  logic                      l_unsigned_i,
    input  logic [MEM_WORD_WIDTH-1:0] wdata_i,
    output logic                      ack_o,
    output logic [MEM_WORD_WIDTH-1:0] rdata_o,
    output logic                      addr_err_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    e_mem_size                 w_size;
    logic [IDX_W-1:0]          w_idx;
    logic [1:0]                w_off;
    logic                      w_oob;
    logic                      w_illegal;
    logic                      w_misalign;
    logic                      w_err;
    logic [3:0]                w_st_be;
    logic [MEM_WORD_WIDTH-1:0] w_st_dat;
    logic [MEM_WORD_WIDTH-1:0] w_ld_dat;

    logic [MEM_WORD_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [MEM_WORD_WIDTH-1:0] r_rd_word;
    logic                      r_s0_vld;
    logic                      r_s0_load;
    logic                      r_s0_err;
    logic [1:0]                r_s0_size;
    logic [1:0]                r_s0_off;
    logic                      r_s0_uns;

    assign w_size    = e_mem_size'(n_bytes_i);
    assign w_idx     = addr_i[IDX_W+1:2];
    assign w_oob     = |addr_i[ADDR_W-1:IDX_W+2];
    assign w_illegal = (w_size == MEM_ILLEGAL);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == MEM_HALF) && addr_i[0]) ||
                        ((w_size == MEM_WORD) && (addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_oob | w_illegal | w_misalign;

    // Alignment is forced here; when trapping, misaligned accesses are already errored.
    always_comb begin
        w_off = addr_i[1:0];
        case (w_size)
            MEM_HALF: w_off = {addr_i[1], 1'b0};
            MEM_WORD: w_off = 2'b00;
            default:  w_off = addr_i[1:0];
        endcase
    end

    dmem_lane_ctrl u_lane (
        .i_st_size     (n_bytes_i),
        .i_st_off      (w_off),
        .i_st_dat      (wdata_i),
        .o_st_be       (w_st_be),
        .o_st_dat      (w_st_dat),
        .i_ld_size     (r_s0_size),
        .i_ld_off      (r_s0_off),
        .i_ld_unsigned (r_s0_uns),
        .i_ld_word     (r_rd_word),
        .o_ld_dat      (w_ld_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst && req_i && write_i && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_st_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_st_dat[8*b +: 8];
                end
            end
        end
        r_rd_word <= r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_vld  <= 1'b0;
            r_s0_load <= 1'b0;
            r_s0_err  <= 1'b0;
            r_s0_size <= 2'b00;
            r_s0_off  <= 2'b00;
            r_s0_uns  <= 1'b0;
        end else begin
            r_s0_vld  <= req_i;
            r_s0_load <= req_i & ~write_i;
            r_s0_err  <= w_err;
            r_s0_size <= n_bytes_i;
            r_s0_off  <= w_off;
            r_s0_uns  <= l_unsigned_i;
        end
    end

    logic [RD_LATENCY-1:0]                     w_vld;
    logic [RD_LATENCY-1:0]                     w_perr;
    logic [RD_LATENCY-1:0][MEM_WORD_WIDTH-1:0] w_pdat;

    assign w_vld[0]  = r_s0_vld;
    assign w_perr[0] = r_s0_vld & r_s0_err;
    assign w_pdat[0] = (r_s0_vld && r_s0_load && !r_s0_err) ? w_ld_dat : '0;

    for (genvar g = 1; g < RD_LATENCY; g++) begin : g_stage
        logic                      r_vld;
        logic                      r_err;
        logic [MEM_WORD_WIDTH-1:0] r_dat;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_err <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_vld[g-1];
                r_err <= w_perr[g-1];
                r_dat <= w_pdat[g-1];
            end
        end

        assign w_vld[g]  = r_vld;
        assign w_perr[g] = r_err;
        assign w_pdat[g] = r_dat;
    end

    assign ack_o      = w_vld[RD_LATENCY-1];
    assign addr_err_o = w_perr[RD_LATENCY-1];
    assign rdata_o    = w_pdat[RD_LATENCY-1];

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder at RD_LATENCY=3; acks are logged with their cycle and compared per scenario.
module tb_data_memory_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        write_i;
    logic [31:0] addr_i;
    logic [1:0]  n_bytes_i;
    logic        l_unsigned_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        addr_err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          q_cyc [$];
    logic [31:0] q_dat [$];
    logic        q_err [$];

    data_memory_responder #(
        .MEM_DEPTH  (1024),
        .ADDR_W     (32),
        .RD_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .write_i      (write_i),
        .addr_i       (addr_i),
        .n_bytes_i    (n_bytes_i),
        .l_unsigned_i (l_unsigned_i),
        .wdata_i      (wdata_i),
        .ack_o        (ack_o),
        .rdata_o      (rdata_o),
        .addr_err_o   (addr_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack_o !== 1'b0) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(rdata_o);
            q_err.push_back(addr_err_o);
        end
    end

    task automatic clear_q();
        q_cyc.delete();
        q_dat.delete();
        q_err.delete();
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] d, output int c);
        @(negedge clk);
        req_i        = 1'b1;
        write_i      = w;
        addr_i       = a;
        n_bytes_i    = sz;
        l_unsigned_i = u;
        wdata_i      = d;
        c            = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_i   = 1'b0;
            write_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        req_i        = 1'b1;
        write_i      = 1'b0;
        addr_i       = 32'h0;
        n_bytes_i    = 2'd2;
        l_unsigned_i = 1'b0;
        wdata_i      = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack cyc%0d got=%b exp=0", i, ack_o); end
            checks++;
            if (rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata cyc%0d got=%h exp=0", i, rdata_o); end
            checks++;
            if (addr_err_o !== 1'b0) begin failures++; $display("FAIL reset_err cyc%0d got=%b exp=0", i, addr_err_o); end
        end
        rst   = 1'b0;
        req_i = 1'b0;
        idle(LAT + 3);
        checks++;
        if (q_cyc.size() != 0) begin failures++; $display("FAIL reset_spurious_ack got=%0d exp=0", q_cyc.size()); end
    endtask

    task automatic test_loads();
        int          c [5];
        logic [31:0] exp_d [5];
        exp_d = '{32'h0, 32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'hDEAD_BEEF};
        clear_q();
        issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, c[0]);
        issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, c[1]);
        issue(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, c[2]);
        issue(1'b0, 32'h10, 2'd1, 1'b0, 32'h0, c[3]);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, c[4]);
        idle(LAT + 2);
        checks++;
        if (q_cyc.size() != 5) begin failures++; $display("FAIL loads_count got=%0d exp=5", q_cyc.size()); end
        for (int i = 0; i < 5 && i < q_cyc.size(); i++) begin
            checks++;
            if (q_cyc[i] != c[i] + LAT) begin failures++; $display("FAIL loads_latency[%0d] got=%0d exp=%0d", i, q_cyc[i], c[i] + LAT); end
            checks++;
            if (q_dat[i] !== exp_d[i]) begin failures++; $display("FAIL loads_rdata[%0d] got=%h exp=%h", i, q_dat[i], exp_d[i]); end
            checks++;
            if (q_err[i] !== 1'b0) begin failures++; $display("FAIL loads_err[%0d] got=%b exp=0", i, q_err[i]); end
        end
    endtask

    task automatic test_byte_store();
        int c [2];
        clear_q();
        issue(1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFF_FF55, c[0]);
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, c[1]);
        idle(LAT + 2);
        checks++;
        if (q_cyc.size() != 2) begin failures++; $display("FAIL sb_count got=%0d exp=2", q_cyc.size()); end
        if (q_cyc.size() == 2) begin
            checks++;
            if (q_dat[0] !== 32'h0) begin failures++; $display("FAIL sb_store_rdata got=%h exp=0", q_dat[0]); end
            checks++;
            if (q_dat[1] !== 32'hDEAD_55EF) begin failures++; $display("FAIL sb_merge got=%h exp=deadt55ef", q_dat[1]); end
            checks++;
            if (q_cyc[1] != c[1] + LAT) begin failures++; $display("FAIL sb_latency got=%0d exp=%0d", q_cyc[1], c[1] + LAT); end
        end
    endtask

    task automatic test_errors();
        int          c [7];
        logic [31:0] exp_d [7];
        logic        exp_e [7];
        exp_d = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'hDEAD_55EF};
        exp_e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_q();
        issue(1'b1, 32'h0,    2'd2, 1'b0, 32'hA5A5_A5A5, c[0]);
        issue(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0,         c[1]);
        issue(1'b1, 32'h1000, 2'd2, 1'b0, 32'h1234_5678, c[2]);
        issue(1'b1, 32'h0,    2'd3, 1'b0, 32'hFFFF_FFFF, c[3]);
        issue(1'b0, 32'h10,   2'd3, 1'b0, 32'h0,         c[4]);
        issue(1'b0, 32'h0,    2'd2, 1'b0, 32'h0,         c[5]);
        issue(1'b0, 32'h10,   2'd2, 1'b0, 32'h0,         c[6]);
        idle(LAT + 2);
        checks++;
        if (q_cyc.size() != 7) begin failures++; $display("FAIL err_count got=%0d exp=7", q_cyc.size()); end
        for (int i = 0; i < 7 && i < q_cyc.size(); i++) begin
            checks++;
            if (q_cyc[i] != c[i] + LAT) begin failures++; $display("FAIL err_latency[%0d] got=%0d exp=%0d", i, q_cyc[i], c[i] + LAT); end
            checks++;
            if (q_dat[i] !== exp_d[i]) begin failures++; $display("FAIL err_rdata[%0d] got=%h exp=%h", i, q_dat[i], exp_d[i]); end
            checks++;
            if (q_err[i] !== exp_e[i]) begin failures++; $display("FAIL err_flag[%0d] got=%b exp=%b", i, q_err[i], exp_e[i]); end
        end
    endtask

    task automatic test_misalign();
        int          c [4];
        logic [31:0] exp_d [4];
        logic        exp_e [4];
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_d = '{32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
        exp_e = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_d = '{32'h0, 32'h0, 32'hCAFE_1234, 32'hCAFE_1234};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        clear_q();
        issue(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFE_F00D, c[0]);
        issue(1'b1, 32'h21, 2'd1, 1'b0, 32'h0000_1234, c[1]);
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0,         c[2]);
        issue(1'b0, 32'h22, 2'd2, 1'b0, 32'h0,         c[3]);
        idle(LAT + 2);
        checks++;
        if (q_cyc.size() != 4) begin failures++; $display("FAIL mis_count got=%0d exp=4", q_cyc.size()); end
        for (int i = 0; i < 4 && i < q_cyc.size(); i++) begin
            checks++;
            if (q_dat[i] !== exp_d[i]) begin failures++; $display("FAIL mis_rdata[%0d] got=%h exp=%h", i, q_dat[i], exp_d[i]); end
            checks++;
            if (q_err[i] !== exp_e[i]) begin failures++; $display("FAIL mis_flag[%0d] got=%b exp=%b", i, q_err[i], exp_e[i]); end
        end
    endtask

    task automatic test_back_to_back_reset();
        int c [8];
        int rst_c;
        int exp_cyc [$];
        clear_q();
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, c[i]);
        @(negedge clk);
        rst   = 1'b1;
        req_i = 1'b0;
        rst_c = cyc;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 4; i < 8; i++) issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, c[i]);
        idle(LAT + 2);
        // Responses still visible in the reset cycle survive; the rest are dropped.
        for (int i = 0; i < 8; i++) begin
            if (i >= 4 || c[i] + LAT <= rst_c) exp_cyc.push_back(c[i] + LAT);
        end
        checks++;
        if (q_cyc.size() != exp_cyc.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", q_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < q_cyc.size(); i++) begin
            checks++;
            if (q_cyc[i] != exp_cyc[i]) begin failures++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, q_cyc[i], exp_cyc[i]); end
            checks++;
            if (q_dat[i] !== 32'hDEAD_55EF) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=dead55ef", i, q_dat[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_byte_store();
        test_errors();
        test_misalign();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
